// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data memory controller
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam string DUMP_FILE = "dataMemory.txt";

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian store merge and load extraction/extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8]       = wdata[7:0];
      SZ_HALF: merged[{lane[1], 4'b0000} +: 16]  = wdata[15:0];
      SZ_WORD: merged                            = wdata;
      default: merged                            = word;
    endcase
  end

  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      SZ_HALF: load_data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - wait-stated byte/half/word data memory with error reporting
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 8192,
  parameter int ADDR_WIDTH  = 15,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [31:0] mem [0:DEPTH_WORDS-1] = '{default: '0};

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic accept, enter_resp, mem_we;

  logic                  cap_write, cap_unsigned;
  logic [1:0]            cap_size;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [31:0]           cap_wdata;

  logic                  a_write, a_unsigned, a_err;
  logic [1:0]            a_size;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_wdata;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0]           rd_word, merged, load_data;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && (state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        if (WAIT_CYCLES > 0) begin
          state_nxt = WAIT;
          cnt_nxt   = WAIT_LOAD;
        end else begin
          state_nxt = RESP;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      cap_write    <= req_write;
      cap_size     <= req_size;
      cap_unsigned <= req_unsigned;
      cap_addr     <= req_addr;
      cap_wdata    <= req_wdata;
    end
  end

  // With no wait states the access happens on the accept edge itself, before capture lands.
  assign a_write    = (state == IDLE) ? req_write    : cap_write;
  assign a_size     = (state == IDLE) ? req_size     : cap_size;
  assign a_unsigned = (state == IDLE) ? req_unsigned : cap_unsigned;
  assign a_addr     = (state == IDLE) ? req_addr     : cap_addr;
  assign a_wdata    = (state == IDLE) ? req_wdata    : cap_wdata;

  assign word_idx = a_addr[ADDR_WIDTH-1:2];
  assign a_err    = (a_size == SZ_RSVD)
                 || ((a_size == SZ_HALF) && a_addr[0])
                 || ((a_size == SZ_WORD) && (a_addr[1:0] != 2'b00))
                 || (32'(word_idx) >= 32'(DEPTH_WORDS));

  assign rd_word    = mem[word_idx[IDX_W-1:0]];
  assign enter_resp = (state != RESP) && (state_nxt == RESP);
  assign mem_we     = enter_resp && a_write && !a_err && !reset;

  dmem_lane_align u_align (
    .word        (rd_word),
    .wdata       (a_wdata),
    .size        (a_size),
    .lane        (a_addr[1:0]),
    .is_unsigned (a_unsigned),
    .merged      (merged),
    .load_data   (load_data)
  );

  always_ff @(posedge clock) begin
    if (mem_we) mem[word_idx[IDX_W-1:0]] <= merged;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (enter_resp) begin
      resp_error <= a_err;
      resp_rdata <= (a_err || a_write) ? 32'd0 : load_data;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        va, vb, ra, rb, rva, rvb, ea, eb;
  logic [31:0] rda, rdb;

  int tests = 0;
  int fails = 0;
  bit [7:0] mdl [0:32767];

  always #5 clock = ~clock;

  data_memory_ctrl #(.DEPTH_WORDS(8192), .ADDR_WIDTH(16), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset), .req_valid(va), .req_ready(ra),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rva), .resp_rdata(rda), .resp_error(ea));

  data_memory_ctrl #(.DEPTH_WORDS(8192), .ADDR_WIDTH(15), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .req_valid(vb), .req_ready(rb),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr[14:0]), .req_wdata(req_wdata),
    .resp_valid(rvb), .resp_rdata(rdb), .resp_error(eb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: errors from the access rules, sign extension by subtraction.
  function automatic void model(input bit wr, input logic [1:0] sz, input bit uns,
                                input int unsigned addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0)
         || (addr / 4 >= 8192);
    rd = 32'd0;
    if (er) return;
    if (wr) begin
      for (int i = 0; i < nb; i++) mdl[addr + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[addr + i];
      if (!uns && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8*nb));
      rd = v;
    end
  endfunction

  // Issue one request to dut_a from a negedge; ends on the negedge after the response.
  task automatic run(input string tag, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [15:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    int lat, rlow;
    bit got;
    logic [31:0] exp_rd;
    logic exp_er;
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    va = 1'b1;
    @(posedge clock);
    lat = 0; rlow = 0; got = 0; rd = 'x; er = 'x;
    while (lat < 40 && !got) begin
      @(negedge clock);
      lat++;
      va = 1'b0;
      req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      req_addr = 16'($urandom); req_wdata = $urandom;
      if (!ra) rlow++;
      if (rva) begin
        got = 1; rd = rda; er = ea;
      end
    end
    model(wr, sz, uns, int'(addr), wd, exp_rd, exp_er);
    chk({tag, " resp seen"}, 32'(got), 32'd1);
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " error"}, 32'(er), 32'(exp_er));
    chk({tag, " latency"}, lat, 3);
    chk({tag, " ready low"}, rlow, 3);
    @(negedge clock);
    chk({tag, " pulse width"}, 32'(rva), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    bit seen;
    int nacc;
    int acc [2];
    logic [5:0] pat;
    logic [31:0] b_rd;
    logic [15:0] ra_addr;

    reset = 1'b1; va = 0; vb = 0;
    req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("reset ready a", 32'(ra), 32'd1);
    chk("reset ready b", 32'(rb), 32'd1);
    chk("reset resp_valid a", 32'(rva), 32'd0);
    chk("reset resp_valid b", 32'(rvb), 32'd0);
    chk("reset rdata a", rda, 32'd0);
    chk("reset error b", 32'(eb), 32'd0);

    run("sw 0x10", 1, 2'b10, 0, 16'h0010, 32'h800000F0, rd, er);
    chk("sw 0x10 rdata zero", rd, 32'd0);
    run("lb 0x10", 0, 2'b00, 0, 16'h0010, 32'h0, rd, er);
    chk("lb const", rd, 32'hFFFFFFF0);
    run("lbu 0x10", 0, 2'b00, 1, 16'h0010, 32'h0, rd, er);
    chk("lbu const", rd, 32'h000000F0);
    run("lh 0x12", 0, 2'b01, 0, 16'h0012, 32'h0, rd, er);
    chk("lh const", rd, 32'hFFFF8000);
    run("lhu 0x12", 0, 2'b01, 1, 16'h0012, 32'h0, rd, er);
    chk("lhu const", rd, 32'h00008000);
    run("lw 0x10", 0, 2'b10, 0, 16'h0010, 32'h0, rd, er);
    chk("lw const", rd, 32'h800000F0);
    run("sb 0x11", 1, 2'b00, 0, 16'h0011, 32'hFFFFFFAB, rd, er);
    run("lw after sb", 0, 2'b10, 0, 16'h0010, 32'h0, rd, er);
    chk("lw after sb const", rd, 32'h8000ABF0);

    run("sh misaligned", 1, 2'b01, 0, 16'h0011, 32'h00001234, rd, er);
    chk("sh misaligned err", 32'(er), 32'd1);
    run("lw after bad sh", 0, 2'b10, 0, 16'h0010, 32'h0, rd, er);
    chk("lw after bad sh const", rd, 32'h8000ABF0);
    run("lw out of range", 0, 2'b10, 0, 16'h8000, 32'h0, rd, er);
    chk("lw oob err", 32'(er), 32'd1);
    run("reserved size", 0, 2'b11, 0, 16'h0010, 32'h0, rd, er);
    chk("reserved err", 32'(er), 32'd1);
    chk("reserved rdata", rd, 32'd0);

    // Reset during the first WAIT cycle, then on the commit edge itself.
    for (int d = 1; d <= 2; d++) begin
      req_write = 1; req_size = 2'b10; req_unsigned = 0; req_addr = 16'h0020;
      req_wdata = 32'h12345678 + 32'(d);
      va = 1'b1; seen = 0;
      @(posedge clock);
      @(negedge clock);
      va = 1'b0;
      if (rva) seen = 1;
      if (d == 2) begin
        @(negedge clock);
        if (rva) seen = 1;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid reset ready", 32'(ra), 32'd1);
      chk("mid reset resp_valid", 32'(rva), 32'd0);
      chk("mid reset no early resp", 32'(seen), 32'd0);
      chk("mid reset rdata cleared", rda, 32'd0);
      @(negedge clock);
      chk("mid reset still no resp", 32'(rva), 32'd0);
      run("lw 0x20 after reset", 0, 2'b10, 0, 16'h0020, 32'h0, rd, er);
      chk("lw 0x20 const", rd, 32'h00000000);
    end

    // Zero-wait instance: two requests with valid held high.
    req_write = 1; req_size = 2'b10; req_unsigned = 0; req_addr = 16'h0040;
    req_wdata = 32'hCAFEBABE;
    vb = 1'b1; nacc = 0; pat = '0; b_rd = 32'hDEADDEAD;
    acc[0] = -1; acc[1] = -1;
    for (int n = 0; n < 6; n++) begin
      if (vb && rb && nacc < 2) begin
        acc[nacc] = n;
        nacc++;
      end
      @(posedge clock);
      @(negedge clock);
      pat[n] = rvb;
      if (rvb && nacc == 2) b_rd = rdb;
      if (nacc == 1) begin
        req_write = 0; req_wdata = 32'h0;
      end
      if (nacc == 2) vb = 1'b0;
    end
    chk("b2b accept count", nacc, 2);
    chk("b2b accept spacing", acc[1] - acc[0], 2);
    chk("b2b resp pattern", 32'(pat), 32'(6'b000101));
    chk("b2b load data", b_rd, 32'hCAFEBABE);
    chk("b2b error", 32'(eb), 32'd0);

    for (int k = 0; k < 150; k++) begin
      ra_addr = ($urandom_range(7, 0) == 0) ? (16'h8000 | 16'($urandom_range(255, 0)))
                                            : 16'($urandom_range(63, 0));
      run("random", 1'($urandom), 2'($urandom), 1'($urandom), ra_addr, $urandom, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
